// File: rtl/qei_pkg.sv
// Shared types and helpers for the quadrature encoder emitter.
// The Gray mapping here must stay identical to the one used by the QEI decoder.
package qei_pkg;

    // Default widths for the emitter and its edge timer.
    localparam int QEI_POS_W_DEF  = 8;
    localparam int QEI_STEP_W_DEF = 16;
    localparam int QEI_DIV_W_DEF  = 16;

    // Command sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } qei_state_t;

    // Phase index to {b,a} output pattern.
    // Consecutive phases differ in exactly one bit, so the output is Gray coded.
    function automatic logic [1:0] phase_to_ab(input logic [1:0] phase);
        logic [1:0] ab;
        case (phase)
            2'd0:    ab = 2'b00;
            2'd1:    ab = 2'b01;
            2'd2:    ab = 2'b11;
            default: ab = 2'b10;
        endcase
        return ab;
    endfunction

    // Inverse of phase_to_ab, mainly for benches observing enc_b/enc_a.
    function automatic logic [1:0] ab_to_phase(input logic [1:0] ab);
        logic [1:0] phase;
        case (ab)
            2'b00:   phase = 2'd0;
            2'b01:   phase = 2'd1;
            2'b11:   phase = 2'd2;
            default: phase = 2'd3;
        endcase
        return phase;
    endfunction

    // One step around the phase circle, wrapping modulo 4 in either direction.
    function automatic logic [1:0] phase_step(input logic [1:0] phase, input logic fwd);
        return fwd ? (phase + 2'd1) : (phase - 2'd1);
    endfunction

endpackage

// File: rtl/qei_edge_timer.sv
// Reload-on-tick down-counter that paces the emitted quadrature edges.
// A load captures the period and starts counting; while enabled, tick is high
// in the cycle the count sits at 1, and the count reloads from the captured period.
module qei_edge_timer
    import qei_pkg::*;
#(
    parameter int DIV_W = QEI_DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] period,
    input  logic             en,
    output logic             tick
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;
    logic [DIV_W-1:0] reload_q;
    logic [DIV_W-1:0] reload_d;

    // Tick when the running count has reached its last cycle.
    assign tick = en && (count_q == DIV_W'(1));

    // Next count: load wins, otherwise count down and reload on the final cycle.
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        if (load) begin
            reload_d = period;
            count_d  = period;
        end else if (en) begin
            if (count_q <= DIV_W'(1)) begin
                count_d = reload_q;
            end else begin
                count_d = count_q - DIV_W'(1);
            end
        end
    end

    // Counter and captured period registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            reload_q <= DIV_W'(1);
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
        end
    end

endmodule

// File: rtl/qei_emitter.sv
// Quadrature encoder emitter: turns signed step commands into a paced
// Gray-coded A/B waveform and keeps a wrapping count of emitted steps.
module qei_emitter
    import qei_pkg::*;
#(
    parameter int bit_width = QEI_POS_W_DEF,
    parameter int STEP_W    = QEI_STEP_W_DEF,
    parameter int DIV_W     = QEI_DIV_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [STEP_W-1:0]    cmd_steps,
    input  logic [DIV_W-1:0]     cmd_period,
    input  logic                 abort,
    output logic                 enc_a,
    output logic                 enc_b,
    output logic                 busy,
    output logic                 done,
    output logic [bit_width-1:0] position
);

    qei_state_t           state_q;
    qei_state_t           state_d;
    logic                 fwd_q;
    logic                 fwd_d;
    logic [STEP_W-1:0]    remaining_q;
    logic [STEP_W-1:0]    remaining_d;
    logic [1:0]           phase_q;
    logic [1:0]           phase_d;
    logic [1:0]           ab_q;
    logic [1:0]           ab_d;
    logic [bit_width-1:0] position_q;
    logic [bit_width-1:0] position_d;
    logic                 cmd_ready_q;
    logic                 cmd_ready_d;

    logic                 accept;
    logic                 tick;
    logic [STEP_W-1:0]    cmd_mag;
    logic [DIV_W-1:0]     period_eff;

    // The step count is two's complement; its magnitude fits STEP_W bits
    // unsigned, so the most negative command is represented exactly.
    // A zero period would never tick, so it is promoted to one cycle.
    always_comb begin
        cmd_mag    = cmd_steps[STEP_W-1] ? ((~cmd_steps) + STEP_W'(1)) : cmd_steps;
        period_eff = (cmd_period == '0) ? DIV_W'(1) : cmd_period;
        accept     = (state_q == IDLE) && cmd_valid && cmd_ready_q;
    end

    qei_edge_timer #(
        .DIV_W (DIV_W)
    ) u_edge_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .period (period_eff),
        .en     (state_q == RUN),
        .tick   (tick)
    );

    // Next-state and datapath: accept in IDLE, step on each tick in RUN
    // (abort takes priority over a tick due in the same cycle), one DONE cycle.
    always_comb begin
        state_d     = state_q;
        fwd_d       = fwd_q;
        remaining_d = remaining_q;
        phase_d     = phase_q;
        position_d  = position_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    fwd_d       = ~cmd_steps[STEP_W-1];
                    remaining_d = cmd_mag;
                    state_d     = (cmd_mag != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    remaining_d = '0;
                    state_d     = DONE;
                end else if (tick) begin
                    phase_d     = phase_step(phase_q, fwd_q);
                    position_d  = fwd_q ? (position_q + bit_width'(1))
                                        : (position_q - bit_width'(1));
                    remaining_d = remaining_q - STEP_W'(1);
                    if (remaining_q == STEP_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ab_d        = phase_to_ab(phase_d);
        cmd_ready_d = (state_d == IDLE);
    end

    // State, phase, output and position registers; A/B and position move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fwd_q       <= 1'b1;
            remaining_q <= '0;
            phase_q     <= 2'd0;
            ab_q        <= 2'b00;
            position_q  <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fwd_q       <= fwd_d;
            remaining_q <= remaining_d;
            phase_q     <= phase_d;
            ab_q        <= ab_d;
            position_q  <= position_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign enc_a     = ab_q[0];
    assign enc_b     = ab_q[1];
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign position  = position_q;
    assign cmd_ready = cmd_ready_q;

endmodule

// File: tb/tb_qei_emitter.sv
// Bench for qei_emitter: a reference model queues every expected A/B edge and
// done pulse (with its cycle) when a command is driven; a monitor pops and
// compares them as the outputs change. A small decoder follows A/B as a loopback.
module tb_qei_emitter;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic [15:0] cmd_period;
    logic        abort;
    logic        enc_a;
    logic        enc_b;
    logic        busy;
    logic        done;
    logic [7:0]  position;

    typedef struct {
        bit         isDone;
        int         cyc;
        logic [1:0] ab;
        logic [7:0] pos;
    } evT;

    evT         expQ[$];
    int         checks;
    int         failures;
    int         cyc;
    int         doneCount;
    logic [1:0] modelPhase;
    logic [7:0] modelPos;
    logic [1:0] prevAb;
    logic [7:0] prevPos;
    logic [1:0] decPrev;
    logic [7:0] decCount;

    qei_emitter dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .busy       (busy),
        .done       (done),
        .position   (position)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so expected events can carry an absolute cycle.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Encoder Gray pattern for a phase, written out independently of the design.
    function automatic logic [1:0] expAb(input logic [1:0] ph);
        case (ph)
            2'd0:    return 2'b00;
            2'd1:    return 2'b01;
            2'd2:    return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Monitor: any A/B or position movement and any done pulse must match the queue head.
    always @(negedge clk) begin
        logic [1:0] curAb;
        evT         e;
        if (rst) begin
            prevAb  = 2'b00;
            prevPos = 8'h00;
        end else begin
            curAb = {enc_b, enc_a};
            if (curAb != prevAb || position != prevPos) begin
                if (curAb != prevAb)
                    checkOutput("one_toggle", $countones(curAb ^ prevAb), 1);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_edge", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("edge_kind", 0, e.isDone);
                    checkOutput("edge_cycle", cyc, e.cyc);
                    checkOutput("edge_ab", curAb, e.ab);
                    checkOutput("edge_pos", position, e.pos);
                end
            end
            if (done) begin
                doneCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("done_kind", 1, e.isDone);
                    checkOutput("done_cycle", cyc, e.cyc);
                    checkOutput("done_ab", curAb, e.ab);
                    checkOutput("done_pos", position, e.pos);
                end
            end
            prevAb  = curAb;
            prevPos = position;
        end
    end

    // Loopback quadrature decoder counting transitions on A/B.
    always @(negedge clk) begin
        logic [1:0] cur;
        if (rst) begin
            decPrev  = 2'b00;
            decCount = 8'h00;
        end else begin
            cur = {enc_b, enc_a};
            case ({decPrev, cur})
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: decCount = decCount + 8'd1;
                4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: decCount = decCount - 8'd1;
                default: ;
            endcase
            decPrev = cur;
        end
    end

    // Drive one command, queue its expected events, optionally abort before
    // edge (abortAfter+1), then wait for done and check the return to IDLE.
    task automatic applyStimulus(input int steps, input int period, input int abortAfter);
        int  n, p, t, nEdges, doneCyc, guard, startDone;
        bit  aborted;
        evT  e;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk); #1;
            guard++;
        end
        if (!cmd_ready) begin
            checkOutput("ready_wait", 0, 1);
            return;
        end
        n       = (steps < 0) ? -steps : steps;
        p       = (period == 0) ? 1 : period;
        aborted = (abortAfter >= 0) && (abortAfter < n);
        nEdges  = aborted ? abortAfter : n;
        doneCyc = aborted ? 0 : 0;
        startDone = doneCount;

        cmd_valid  = 1'b1;
        cmd_steps  = 16'(steps);
        cmd_period = 16'(period);
        t = cyc + 1;
        for (int k = 1; k <= nEdges; k++) begin
            modelPhase = (steps > 0) ? modelPhase + 2'd1 : modelPhase - 2'd1;
            modelPos   = (steps > 0) ? modelPos + 8'd1 : modelPos - 8'd1;
            e.isDone = 1'b0; e.cyc = t + k * p; e.ab = expAb(modelPhase); e.pos = modelPos;
            expQ.push_back(e);
        end
        doneCyc = aborted ? t + (abortAfter + 1) * p : t + n * p;
        e.isDone = 1'b1; e.cyc = doneCyc; e.ab = expAb(modelPhase); e.pos = modelPos;
        expQ.push_back(e);

        @(negedge clk); #1;
        cmd_valid = 1'b0;
        checkOutput("ready_low", cmd_ready, 0);
        checkOutput("busy", busy, (n != 0) ? 1 : 0);

        if (aborted) begin
            guard = 0;
            while (cyc < doneCyc - 1 && guard < n * p + 20) begin
                @(negedge clk); #1;
                guard++;
            end
            abort = 1'b1;
            @(negedge clk); #1;
            abort = 1'b0;
        end

        guard = 0;
        while (doneCount == startDone && guard < n * p + 20) begin
            @(negedge clk); #1;
            guard++;
        end
        if (doneCount == startDone) begin
            checkOutput("done_timeout", 0, 1);
            return;
        end
        @(negedge clk); #1;
        checkOutput("ready_back", cmd_ready, 1);
        checkOutput("done_len", done, 0);
        checkOutput("queue_empty", expQ.size(), 0);
        checkOutput("loopback", decCount, modelPos);
    endtask

    // Synchronous reset for a few cycles; model restarts from phase 0.
    task automatic doReset();
        rst = 1'b1;
        expQ.delete();
        modelPhase = 2'd0;
        modelPos   = 8'h00;
        repeat (3) begin
            @(negedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk); #1;
    endtask

    initial begin
        int s, pr, ab, n;
        checks     = 0;
        failures   = 0;
        doneCount  = 0;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_steps  = '0;
        cmd_period = '0;
        abort      = 1'b0;
        modelPhase = 2'd0;
        modelPos   = 8'h00;

        // Reset values, then ready exactly one cycle after release.
        repeat (3) begin
            @(negedge clk); #1;
        end
        checkOutput("rst_enc_a", enc_a, 0);
        checkOutput("rst_enc_b", enc_b, 0);
        checkOutput("rst_position", position, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ready", cmd_ready, 0);
        rst = 1'b0;
        @(negedge clk); #1;
        checkOutput("ready_after_rst", cmd_ready, 1);

        // Forward three steps, four cycles apart.
        applyStimulus(3, 4, -1);
        checkOutput("fwd_pos", position, 3);
        checkOutput("fwd_ab", {enc_b, enc_a}, 2'b10);

        // Reverse through zero, then a long forward run wrapping the counter.
        doReset();
        applyStimulus(-2, 1, -1);
        checkOutput("rev_pos", position, 8'hFE);
        checkOutput("rev_ab", {enc_b, enc_a}, 2'b11);
        applyStimulus(260, 1, -1);
        checkOutput("wrap_pos", position, 8'h02);
        checkOutput("wrap_ab", {enc_b, enc_a}, 2'b11);

        // Abort when the third edge is due: only two edges, then silence.
        doReset();
        applyStimulus(10, 5, 2);
        checkOutput("abort_pos", position, 2);
        repeat (12) begin
            @(negedge clk); #1;
        end
        checkOutput("abort_quiet_pos", position, 2);

        // Zero steps with abort held in IDLE: still accepted, done next cycle.
        abort = 1'b1;
        applyStimulus(0, 3, -1);
        abort = 1'b0;
        checkOutput("zero_pos", position, 2);

        // Period zero acts as one; most negative command emits full count.
        applyStimulus(3, 0, -1);
        checkOutput("per0_pos", position, 5);
        applyStimulus(-32768, 1, -1);
        checkOutput("neg_max_pos", position, 8'(5 - 32768));

        // Reset in the middle of a command: no done pulse, everything cleared.
        begin
            evT e;
            int t, startDone;
            startDone  = doneCount;
            cmd_valid  = 1'b1;
            cmd_steps  = 16'd5;
            cmd_period = 16'd2;
            t = cyc + 1;
            for (int k = 1; k <= 2; k++) begin
                modelPhase = modelPhase + 2'd1;
                modelPos   = modelPos + 8'd1;
                e.isDone = 1'b0; e.cyc = t + 2 * k; e.ab = expAb(modelPhase); e.pos = modelPos;
                expQ.push_back(e);
            end
            @(negedge clk); #1;
            cmd_valid = 1'b0;
            repeat (4) begin
                @(negedge clk); #1;
            end
            checkOutput("mid_edges_seen", expQ.size(), 0);
            rst = 1'b1;
            @(negedge clk); #1;
            checkOutput("mid_rst_pos", position, 0);
            checkOutput("mid_rst_ab", {enc_b, enc_a}, 0);
            checkOutput("mid_rst_busy", busy, 0);
            rst = 1'b0;
            modelPhase = 2'd0;
            modelPos   = 8'h00;
            repeat (3) begin
                @(negedge clk); #1;
            end
            checkOutput("mid_rst_no_done", doneCount, startDone);
            checkOutput("mid_rst_ready", cmd_ready, 1);
        end

        // Random command sequence checked against the loopback decoder.
        for (int i = 0; i < 12; i++) begin
            s  = int'($urandom_range(0, 40)) - 20;
            pr = int'($urandom_range(0, 3));
            n  = (s < 0) ? -s : s;
            ab = ($urandom_range(0, 3) == 0 && n > 1) ? int'($urandom_range(0, n - 1)) : -1;
            applyStimulus(s, pr, ab);
        end

        $display("[TB] stimulus complete after %0d cycles", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qei_emitter.md
# qei_emitter

Quadrature encoder emitter: converts signed step commands into a two-phase Gray-coded A/B waveform, paced by a per-command edge period, and tracks the emitted position. It is the transmit-side counterpart of the QEI decoder. It drives encoder-simulation outputs for bring-up and hardware-in-the-loop tests, and its A/B outputs loop back directly into a QEI decoder input.

## Interface
- `bit_width`, 8, width of the `position` counter; matches the QEI decoder count width.
- `STEP_W`, 16, width of the signed step command.
- `DIV_W`, 16, width of the edge-period field.
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset; synchronous and active-high.
- `cmd_valid`  in  1  step command offered.
- `cmd_ready`  out  1  block can accept a command (registered).
- `cmd_steps`  in  STEP_W  signed step count; positive means forward (A leads B).
- `cmd_period`  in  DIV_W  clock cycles between successive edges; 0 is treated as 1.
- `abort`  in  1  level input; ends the running command before its next edge.
- `enc_a`  out  1  quadrature phase A (registered).
- `enc_b`  out  1  quadrature phase B (registered).
- `busy`  out  1  command in progress (state RUN).
- `done`  out  1  one-cycle pulse when a command completes or is aborted.
- `position`  out  bit_width  running emitted position; wraps modulo 2^bit_width.

## Operation
- 2-bit phase register drives the outputs as {enc_b,enc_a}: phase 0 = 00, 1 = 01, 2 = 11, 3 = 10.
- A forward step sets phase+1 mod 4 and position+1. A reverse step sets phase−1 mod 4 and position−1. Both use modulo arithmetic with no saturation.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`, the block latches:
    - direction = sign of `cmd_steps`;
    - remaining = |`cmd_steps`| as STEP_W-bit unsigned, so −2^(STEP_W−1) is exact;
    - period = max(`cmd_period`,1).
  - The timer loads with period.
  - Next state: RUN if remaining≠0, else DONE.
- **RUN**
  - `busy`=1. The timer decrements each cycle.
  - When the timer reaches 1, the block emits one step, decrements remaining, and reloads the timer.
  - After the last step, next state is DONE.
- **DONE**
  - `done`=1 for exactly one cycle. Next state is IDLE.
- **abort**
  - Sampled only in RUN. It forces DONE and suppresses any edge due in the same cycle.
  - Remaining steps are discarded. Phase and position are held.
  - Ignored in IDLE and DONE. In IDLE, `cmd_valid` together with `abort` is accepted normally.
- **Edge shape**
  - Exactly one of A/B toggles per step; both never change in the same cycle.
  - Direction reversal between commands continues from the current phase, with no glitch.
- **Reset mid-command**
  - Returns to IDLE immediately. Remaining steps are lost and no `done` pulse is issued.

## Timing
- Reset values: `enc_a`=0, `enc_b`=0, phase=0, `position`=0, `busy`=0, `done`=0, `cmd_ready`=0.
- `cmd_ready` rises the first cycle after `rst` deasserts.
- Command accepted at clock edge T:
  - `cmd_ready`=0 from T+1.
  - Edge k (k=1..N) appears on `enc_a`/`enc_b` and `position` at edge T+k·P.
  - `done`=1 in cycle T+N·P+1.
  - `cmd_ready`=1 again from T+N·P+2.
- N=0: `done` at T+1, `cmd_ready` back at T+2, and the outputs do not move.
- Back-to-back throughput: one command per N·P+2 cycles.
- `position` updates on the same clock edge as the corresponding A/B change. There is no extra latency.

## Structure
- Package `qei_pkg` holds:
  - `qei_state_t` enum {IDLE, RUN, DONE};
  - function `phase_to_ab` (2-bit phase → {b,a}), which must match the decoder's Gray mapping;
  - function `ab_to_phase`, for benches.
- Sub-module `qei_edge_timer`:
  - inputs: `clk`, `rst`, `load`, `period`, `en`;
  - output: `tick`;
  - reload-on-tick down-counter, DIV_W wide.
- Top level holds the FSM, step counter, phase and position registers.

## Test plan
- **Reset:** assert `rst` 3 cycles → all outputs 0. `cmd_ready`=1 exactly 1 cycle after release.
- **Forward:** steps=+3, period=4, accepted at T:
  - {b,a}=01 @T+4, 11 @T+8, 10 @T+12;
  - `position`=3;
  - `done` @T+13.
- **Reverse and wrap:** from reset, steps=−2, period=1:
  - {b,a}=10 then 11;
  - `position`=0xFE.
  - Then steps=+260, period=1: `position`=0x02, {b,a}=11.
- **Abort:** steps=+10, period=5; raise `abort` in the cycle the 3rd edge is due:
  - only 2 edges occur;
  - `position`=2;
  - `done` next cycle; no further A/B activity.
- **Corners:** steps=0 → `done` @T+1 with no edges. period=0 behaves as period=1. steps=−32768 emits 32768 reverse edges.
- **Loopback:** outputs feed a QEI decoder (bit_width=8) for a random command sequence → decoder count equals `position` after every `done`.
